// File: rtl/pwm_shadow_update_ctrl_if.sv
// Software-side bus for the PWM shadow update controller: shadow writes and commits.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. ready may depend combinationally on the request fields (wr_ready
// depends on wr_chan). The master holds its fields stable while valid is high.
// The slave never waits for valid before raising ready.
interface pwm_shadow_update_ctrl_if #(
  parameter int PWM_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
);
  localparam int CHAN_W = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [CHAN_W-1:0]      wr_chan;
  logic                   wr_sel;
  logic [COUNT_WIDTH-1:0] wr_data;

  logic                   commit_valid;
  logic                   commit_ready;
  logic [PWM_WIDTH-1:0]   commit_mask;
  logic                   commit_force;

  modport master (
    output wr_valid, wr_chan, wr_sel, wr_data,
    output commit_valid, commit_mask, commit_force,
    input  wr_ready, commit_ready
  );

  modport slave (
    input  wr_valid, wr_chan, wr_sel, wr_data,
    input  commit_valid, commit_mask, commit_force,
    output wr_ready, commit_ready
  );
endinterface

// File: rtl/pwm_shadow_update_ctrl.sv
// Double-buffered period/compare scheduler for the PWM core. Software fills
// per-channel shadow registers and commits a channel mask; each masked channel
// copies shadow to active only on a rising edge of its carrier event, so a PWM
// period is never torn. Forced commits or a stopped PWM apply immediately.
module pwm_shadow_update_ctrl #(
  parameter int PWM_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pwm_onoff,
  pwm_shadow_update_ctrl_if.slave          bus,
  input  logic [PWM_WIDTH-1:0]             maskevent_x,
  output logic [COUNT_WIDTH*PWM_WIDTH-1:0] period_x,
  output logic [COUNT_WIDTH*PWM_WIDTH-1:0] compare_x,
  output logic [PWM_WIDTH-1:0]             pending_x,
  output logic                             update_done,
  output logic                             timeout_err,
  output logic [1:0]                       fsm_state
);

  localparam int CHAN_W = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1
  } state_t;

  state_t                 state, state_nxt;
  logic [PWM_WIDTH-1:0]   pending, pending_nxt, pending_rem;
  logic [PWM_WIDTH-1:0]   maskevent_d;
  logic [PWM_WIDTH-1:0]   evt;
  logic [PWM_WIDTH-1:0]   wr_hit;
  logic [PWM_WIDTH-1:0]   load;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   done_nxt;
  logic                   err_nxt;
  logic                   wr_ready_int;
  logic                   commit_acc;

  logic [COUNT_WIDTH-1:0] shadow_per [PWM_WIDTH];
  logic [COUNT_WIDTH-1:0] shadow_cmp [PWM_WIDTH];
  logic [COUNT_WIDTH-1:0] shadow_per_in [PWM_WIDTH];
  logic [COUNT_WIDTH-1:0] shadow_cmp_in [PWM_WIDTH];
  logic [COUNT_WIDTH-1:0] active_per [PWM_WIDTH];
  logic [COUNT_WIDTH-1:0] active_cmp [PWM_WIDTH];

  // Only rising edges of the carrier events count as transfer points.
  assign evt = maskevent_x & ~maskevent_d;

  assign bus.wr_ready     = wr_ready_int;
  assign bus.commit_ready = (state == ST_IDLE);
  assign commit_acc       = bus.commit_valid && (state == ST_IDLE);

  assign pending_x = pending;
  assign fsm_state = state;

  // Pack active registers onto the flat core-facing buses.
  for (genvar j = 0; j < PWM_WIDTH; j++) begin : g_pack
    assign period_x[COUNT_WIDTH*j +: COUNT_WIDTH]  = active_per[j];
    assign compare_x[COUNT_WIDTH*j +: COUNT_WIDTH] = active_cmp[j];
  end

  // Write acceptance: a pending channel's shadow is frozen until it transfers.
  // An out-of-range channel index is accepted and discarded.
  always_comb begin
    wr_ready_int = 1'b1;
    wr_hit       = '0;
    for (int i = 0; i < PWM_WIDTH; i++) begin
      if (bus.wr_chan == CHAN_W'(i)) begin
        wr_ready_int = ~pending[i];
        wr_hit[i]    = bus.wr_valid & ~pending[i];
      end
    end
  end

  // Shadow values as they stand after this edge's write; a write in the same
  // cycle as an immediate commit is therefore included in that commit.
  always_comb begin
    for (int i = 0; i < PWM_WIDTH; i++) begin
      shadow_per_in[i] = (wr_hit[i] &&  bus.wr_sel) ? bus.wr_data : shadow_per[i];
      shadow_cmp_in[i] = (wr_hit[i] && !bus.wr_sel) ? bus.wr_data : shadow_cmp[i];
    end
  end

  // Next-state logic: commit handling, event-driven transfers and timeout.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    pending_rem = pending;
    load        = '0;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    err_nxt     = timeout_err;
    unique case (state)
      ST_IDLE: begin
        if (commit_acc && (bus.commit_mask != '0)) begin
          err_nxt = 1'b0;
          if (bus.commit_force || !pwm_onoff) begin
            load     = bus.commit_mask;
            done_nxt = 1'b1;
          end else begin
            pending_nxt = bus.commit_mask;
            cnt_nxt     = '0;
            state_nxt   = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A stopped carrier produces no events, so flush everything left.
        if (!pwm_onoff) begin
          load = pending;
        end else begin
          load = pending & evt;
        end
        pending_rem = pending & ~load;
        if (pending_rem == '0) begin
          pending_nxt = '0;
          done_nxt    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          // Abort: channels that saw an event this cycle still transferred.
          pending_nxt = '0;
          err_nxt     = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_IDLE;
        end else begin
          pending_nxt = pending_rem;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        pending_nxt = '0;
        cnt_nxt     = '0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      cnt         <= '0;
      update_done <= 1'b0;
      timeout_err <= 1'b0;
      maskevent_d <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      cnt         <= cnt_nxt;
      update_done <= done_nxt;
      timeout_err <= err_nxt;
      maskevent_d <= maskevent_x;
    end
  end

  // Shadow registers: written only by software, never by transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PWM_WIDTH; i++) begin
        shadow_per[i] <= '0;
        shadow_cmp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PWM_WIDTH; i++) begin
        shadow_per[i] <= shadow_per_in[i];
        shadow_cmp[i] <= shadow_cmp_in[i];
      end
    end
  end

  // Active registers: reload from the shadows for every channel in load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PWM_WIDTH; i++) begin
        active_per[i] <= '0;
        active_cmp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PWM_WIDTH; i++) begin
        if (load[i]) begin
          active_per[i] <= shadow_per_in[i];
          active_cmp[i] <= shadow_cmp_in[i];
        end
      end
    end
  end

endmodule
